// File: rtl/alu_pkg.sv
// Shared definitions for the tile ALU command driver.
// Opcodes, flag selects, pin bit positions and FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SHR = 3'b010;
  localparam logic [2:0] ALU_SHL = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  localparam logic [1:0] FSEL_GT   = 2'b00;
  localparam logic [1:0] FSEL_EQ   = 2'b01;
  localparam logic [1:0] FSEL_Z    = 2'b10;
  localparam logic [1:0] FSEL_EVEN = 2'b11;

  localparam int ALU_CTRL_ENA = 3;
  localparam int ALU_HI_FLAG  = 6;
  localparam int ALU_HI_OVF   = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_RESP   = 3'd4
  } drv_state_e;

  function automatic logic [7:0] mk_ctrl(
    input logic [1:0] fsel,
    input logic       ena,
    input logic [2:0] op
  );
    logic [7:0] c;
    c = {2'b00, fsel, 1'b0, op};
    c[ALU_CTRL_ENA] = ena;
    return c;
  endfunction

endpackage

// File: rtl/alu_cmd_driver.sv
// Sequences the tile ALU pin bus: load A, load B, settle, capture.
// One request in flight; response held until the host accepts it.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_fsel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [13:0] rsp_result,
  output logic        rsp_flag,
  output logic        rsp_ovf,
  output logic [7:0]  alu_data,
  output logic [7:0]  alu_ctrl,
  input  logic [7:0]  alu_res_lo,
  input  logic [7:0]  alu_res_hi
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  drv_state_e    state_q;
  logic [7:0]    b_q;
  logic [2:0]    op_q;
  logic [1:0]    fsel_q;
  logic [CW-1:0] cnt_q;
  logic          rsp_valid_q;
  logic [13:0]   rsp_result_q;
  logic          rsp_flag_q;
  logic          rsp_ovf_q;
  logic [7:0]    alu_data_q;
  logic [7:0]    alu_ctrl_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      b_q          <= '0;
      op_q         <= '0;
      fsel_q       <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      alu_data_q   <= '0;
      alu_ctrl_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            b_q        <= cmd_b;
            op_q       <= cmd_op;
            fsel_q     <= cmd_fsel;
            alu_data_q <= cmd_a;
            alu_ctrl_q <= mk_ctrl(cmd_fsel, 1'b1, cmd_op);
            state_q    <= ST_LOAD_A;
          end
        end
        ST_LOAD_A: begin
          alu_data_q <= b_q;
          alu_ctrl_q <= mk_ctrl(fsel_q, 1'b0, op_q);
          state_q    <= ST_LOAD_B;
        end
        ST_LOAD_B: begin
          cnt_q   <= CNT_LD;
          state_q <= ST_EXEC;
        end
        // Data stays at B: the ALU reloads B on every enA=0 edge.
        ST_EXEC: begin
          if (cnt_q == '0) begin
            rsp_result_q <= {alu_res_hi[5:0], alu_res_lo};
            rsp_flag_q   <= alu_res_hi[ALU_HI_FLAG];
            rsp_ovf_q    <= alu_res_hi[ALU_HI_OVF];
            rsp_valid_q  <= 1'b1;
            alu_data_q   <= '0;
            alu_ctrl_q   <= '0;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = rst_n && (state_q == ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flag   = rsp_flag_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign alu_data   = alu_data_q;
  assign alu_ctrl   = alu_ctrl_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural ALU tile model.
// Two instances: settle of 1 and settle of 3 cycles.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 1: SETTLE_CYCLES=1
  logic        cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1;
  logic [7:0]  cmd_a1, cmd_b1;
  logic [2:0]  cmd_op1;
  logic [1:0]  cmd_fsel1;
  logic [13:0] rsp_result1;
  logic        rsp_flag1, rsp_ovf1;
  logic [7:0]  alu_data1, alu_ctrl1, alu_lo1, alu_hi1;

  // Instance 3: SETTLE_CYCLES=3
  logic        cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3;
  logic [7:0]  cmd_a3, cmd_b3;
  logic [2:0]  cmd_op3;
  logic [1:0]  cmd_fsel3;
  logic [13:0] rsp_result3;
  logic        rsp_flag3, rsp_ovf3;
  logic [7:0]  alu_data3, alu_ctrl3, alu_lo3, alu_hi3;

  alu_cmd_driver #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_a(cmd_a1), .cmd_b(cmd_b1),
    .cmd_op(cmd_op1), .cmd_fsel(cmd_fsel1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_result(rsp_result1), .rsp_flag(rsp_flag1),
    .rsp_ovf(rsp_ovf1),
    .alu_data(alu_data1), .alu_ctrl(alu_ctrl1),
    .alu_res_lo(alu_lo1), .alu_res_hi(alu_hi1)
  );

  alu_cmd_driver #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3),
    .cmd_op(cmd_op3), .cmd_fsel(cmd_fsel3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_result(rsp_result3), .rsp_flag(rsp_flag3),
    .rsp_ovf(rsp_ovf3),
    .alu_data(alu_data3), .alu_ctrl(alu_ctrl3),
    .alu_res_lo(alu_lo3), .alu_res_hi(alu_hi3)
  );

  // ALU tile model: returns {uio_out, uo_out}
  function automatic logic [15:0] alu_f(
    input logic [7:0] a, input logic [7:0] b,
    input logic [2:0] op, input logic [1:0] fs
  );
    logic [15:0] r;
    logic f;
    case (op)
      ALU_ADD: r = {8'd0, a} + {8'd0, b};
      ALU_SUB: r = {8'd0, a} - {8'd0, b};
      ALU_SHR: r = {9'd0, a[7:1]};
      ALU_SHL: r = {7'd0, a, 1'b0};
      ALU_AND: r = {8'd0, a & b};
      ALU_OR:  r = {8'd0, a | b};
      ALU_XOR: r = {8'd0, a ^ b};
      default: r = {8'd0, a} * {8'd0, b};
    endcase
    case (fs)
      FSEL_GT: f = (a > b);
      FSEL_EQ: f = (a == b);
      FSEL_Z:  f = (a == 8'd0);
      default: f = ~a[0];
    endcase
    return {(r[15:8] != 8'd0), f, r[13:8], r[7:0]};
  endfunction

  logic [7:0] ra1 = 8'd0, rb1 = 8'd0, ra3 = 8'd0, rb3 = 8'd0;
  always @(posedge clk) begin
    if (alu_ctrl1[3]) ra1 <= alu_data1;
    else rb1 <= alu_data1;
    if (alu_ctrl3[3]) ra3 <= alu_data3;
    else rb3 <= alu_data3;
  end
  assign {alu_hi1, alu_lo1} =
    alu_f(ra1, rb1, alu_ctrl1[2:0], alu_ctrl1[5:4]);
  assign {alu_hi3, alu_lo3} =
    alu_f(ra3, rb3, alu_ctrl3[2:0], alu_ctrl3[5:4]);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [1:0]  fs;
    logic [13:0] res;
    logic        flag;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];
  logic en_seq[3];
  int   last_rsp_cyc;

  // Full transaction on dut1 with rsp_ready held high.
  task automatic run1(input vec_t v, input int idx);
    int w;
    int lat;
    string p;
    p = $sformatf("v%0d", idx);
    cmd_a1 = v.a; cmd_b1 = v.b;
    cmd_op1 = v.op; cmd_fsel1 = v.fs;
    cmd_valid1 = 1'b1; rsp_ready1 = 1'b1;
    w = 0;
    while (!cmd_ready1 && w < 20) begin tick(); w++; end
    chk({p, "_ready"}, 32'(cmd_ready1), 32'd1);
    tick();
    cmd_valid1 = 1'b0;
    en_seq[0] = alu_ctrl1[3];
    chk({p, "_dataA"}, 32'(alu_data1), 32'(v.a));
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat <= 2) en_seq[lat] = alu_ctrl1[3];
      if (lat == 1) chk({p, "_dataB"}, 32'(alu_data1), 32'(v.b));
    end while (!rsp_valid1 && lat < 20);
    last_rsp_cyc = cyc;
    chk({p, "_lat"}, 32'(lat), 32'd3);
    chk({p, "_res"}, 32'(rsp_result1), 32'(v.res));
    chk({p, "_flag"}, 32'(rsp_flag1), 32'(v.flag));
    chk({p, "_ovf"}, 32'(rsp_ovf1), 32'(v.ovf));
    tick();
    chk({p, "_vdrop"}, 32'(rsp_valid1), 32'd0);
  endtask

  initial begin
    int w, lat, c1;
    logic seen;
    vecs[0] = '{8'd200, 8'd100, ALU_ADD, FSEL_GT, 14'h012C, 1'b1, 1'b1};
    vecs[1] = '{8'd5, 8'd7, ALU_SUB, FSEL_EQ, 14'h3FFE, 1'b0, 1'b1};
    vecs[2] = '{8'h81, 8'h00, ALU_SHR, FSEL_EVEN, 14'h0040, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 8'h00, ALU_SHL, FSEL_Z, 14'h0102, 1'b0, 1'b1};
    vecs[4] = '{8'hAA, 8'h0F, ALU_AND, FSEL_EQ, 14'h000A, 1'b0, 1'b0};
    vecs[5] = '{8'hAA, 8'h0F, ALU_OR, FSEL_GT, 14'h00AF, 1'b1, 1'b0};
    vecs[6] = '{8'h3C, 8'h3C, ALU_XOR, FSEL_EQ, 14'h0000, 1'b1, 1'b0};
    vecs[7] = '{8'd16, 8'd16, ALU_MUL, FSEL_EVEN, 14'h0100, 1'b1, 1'b1};
    vecs[8] = '{8'd0, 8'd0, ALU_ADD, FSEL_Z, 14'h0000, 1'b1, 1'b0};
    vecs[9] = '{8'd7, 8'd5, ALU_SUB, FSEL_GT, 14'h0002, 1'b1, 1'b0};

    cmd_valid1 = 0; cmd_a1 = 0; cmd_b1 = 0; cmd_op1 = 0; cmd_fsel1 = 0;
    rsp_ready1 = 0;
    cmd_valid3 = 0; cmd_a3 = 0; cmd_b3 = 0; cmd_op3 = 0; cmd_fsel3 = 0;
    rsp_ready3 = 1;

    // Reset state
    rst_n = 0;
    repeat (3) tick();
    chk("rst_valid", 32'(rsp_valid1), 32'd0);
    chk("rst_result", 32'(rsp_result1), 32'd0);
    chk("rst_flagovf", 32'({rsp_flag1, rsp_ovf1}), 32'd0);
    chk("rst_data", 32'(alu_data1), 32'd0);
    chk("rst_ctrl", 32'(alu_ctrl1), 32'd0);
    chk("rst_ready_low", 32'(cmd_ready1), 32'd0);
    rst_n = 1;
    #1;
    chk("rst_ready_high", 32'(cmd_ready1), 32'd1);
    tick();

    // Table-driven vectors
    for (int i = 0; i < 10; i++) run1(vecs[i], i);

    // MUL 255*255 with settle of 3
    cmd_a3 = 8'd255; cmd_b3 = 8'd255;
    cmd_op3 = ALU_MUL; cmd_fsel3 = FSEL_Z;
    cmd_valid3 = 1;
    chk("mul3_ready", 32'(cmd_ready3), 32'd1);
    tick();
    cmd_valid3 = 0;
    lat = 0;
    do begin tick(); lat++; end while (!rsp_valid3 && lat < 20);
    chk("mul3_lat", 32'(lat), 32'd5);
    chk("mul3_res", 32'(rsp_result3), 32'h3E01);
    chk("mul3_flag", 32'(rsp_flag3), 32'd0);
    chk("mul3_ovf", 32'(rsp_ovf3), 32'd1);
    tick();

    // Backpressure on XOR
    rsp_ready1 = 0;
    cmd_a1 = 8'hF0; cmd_b1 = 8'h0F;
    cmd_op1 = ALU_XOR; cmd_fsel1 = FSEL_GT;
    cmd_valid1 = 1;
    tick();
    cmd_valid1 = 0;
    w = 0;
    while (!rsp_valid1 && w < 20) begin tick(); w++; end
    chk("bp_valid", 32'(rsp_valid1), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cmd_valid1 = ~cmd_valid1;
      cmd_a1 = 8'(i * 17); cmd_b1 = 8'(i + 3);
      cmd_op1 = ALU_ADD;
      tick();
      chk($sformatf("bp_res%0d", i), 32'(rsp_result1), 32'h00FF);
      chk($sformatf("bp_ovf%0d", i), 32'(rsp_ovf1), 32'd0);
      chk($sformatf("bp_hold%0d", i), 32'(rsp_valid1), 32'd1);
      chk($sformatf("bp_crdy%0d", i), 32'(cmd_ready1), 32'd0);
    end
    cmd_valid1 = 0;
    rsp_ready1 = 1;
    tick();
    chk("bp_done", 32'(rsp_valid1), 32'd0);
    chk("bp_idle", 32'(cmd_ready1), 32'd1);
    tick();
    chk("bp_noacc", 32'(alu_ctrl1), 32'd0);

    // Reset during LOAD_B
    cmd_a1 = 8'd200; cmd_b1 = 8'd100;
    cmd_op1 = ALU_ADD; cmd_fsel1 = FSEL_GT;
    cmd_valid1 = 1;
    tick();
    cmd_valid1 = 0;
    tick();
    rst_n = 0;
    tick();
    chk("mrst_ctrl", 32'(alu_ctrl1), 32'd0);
    chk("mrst_valid", 32'(rsp_valid1), 32'd0);
    rst_n = 1;
    #1;
    chk("mrst_idle", 32'(cmd_ready1), 32'd1);
    seen = 0;
    repeat (6) begin tick(); seen |= rsp_valid1; end
    chk("mrst_norsp", 32'(seen), 32'd0);
    run1(vecs[0], 100);

    // Back-to-back AND then OR
    run1(vecs[4], 4);
    chk("b2b_en0a", 32'({en_seq[0], en_seq[1], en_seq[2]}), 32'b100);
    c1 = last_rsp_cyc;
    run1(vecs[5], 5);
    chk("b2b_en0b", 32'({en_seq[0], en_seq[1], en_seq[2]}), 32'b100);
    chk("b2b_gap", 32'(last_rsp_cyc - c1), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
